sample_reader: RTL and testbench

Downstream stage of `sampler`. When activated by the top-level state watcher (state 0x22), it reads every entry of the sample memory in address order and streams it out on a UART transmit line, preceded by one header byte. The frame is 8N1, LSB first. The block uses the same `activate`/`done` level handshake as `sampler` and `test`. It owns the read side of the sample memory (`addr_out`, `data_out`, `oe`).

---
 rtl/sample_reader.sv | 153 +++++++++++++++
 tb/tb_sample_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_reader.sv
// UART dump of the sample memory: one header byte, then DEPTH samples in address
// order, 8N1 LSB first, under the activate/done level handshake.
module sample_reader #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          ADDR_WIDTH   = 8,
   parameter int          DEPTH        = 256,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic                  clk_50mhz,
   input  logic                  reset,
   input  logic                  activate,
   output logic                  done,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_oe,
   input  logic [7:0]            mem_data,
   output logic                  txd
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0]         T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP, FIN} state_t;

   state_t                state;
   logic [TW-1:0]         timer;
   logic [2:0]            bit_idx;
   logic [ADDR_WIDTH-1:0] addr;
   logic [7:0]            shreg;
   logic                  hdr;
   logic                  abort;
   logic                  bit_end;

   assign bit_end = (timer == T_LAST);

   always_ff @(posedge clk_50mhz) begin
      if (!reset) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         addr     <= '0;
         shreg    <= '0;
         hdr      <= 1'b0;
         abort    <= 1'b0;
         txd      <= 1'b1;
         done     <= 1'b0;
         busy     <= 1'b0;
         mem_oe   <= 1'b0;
         mem_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               txd    <= 1'b1;
               done   <= 1'b0;
               mem_oe <= 1'b0;
               // after an abort, activate must be seen low before another frame may start
               if (!activate) begin
                  abort <= 1'b0;
               end else if (!abort) begin
                  shreg <= HEADER;
                  hdr   <= 1'b1;
                  timer <= '0;
                  txd   <= 1'b0;
                  busy  <= 1'b1;
                  state <= START;
               end
            end
            FETCH: begin
               if (!activate) begin
                  abort  <= 1'b1;
                  busy   <= 1'b0;
                  mem_oe <= 1'b0;
                  state  <= IDLE;
               end else begin
                  state <= LATCH;
               end
            end
            LATCH: begin
               if (!activate) begin
                  abort  <= 1'b1;
                  busy   <= 1'b0;
                  mem_oe <= 1'b0;
                  state  <= IDLE;
               end else begin
                  shreg  <= mem_data;
                  mem_oe <= 1'b0;
                  timer  <= '0;
                  txd    <= 1'b0;
                  state  <= START;
               end
            end
            START: begin
               if (!activate) abort <= 1'b1;
               timer <= bit_end ? '0 : timer + 1'b1;
               if (bit_end) begin
                  bit_idx <= '0;
                  txd     <= shreg[0];
                  state   <= DATA;
               end
            end
            DATA: begin
               if (!activate) abort <= 1'b1;
               timer <= bit_end ? '0 : timer + 1'b1;
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= {1'b0, shreg[7:1]};
                     txd     <= shreg[1];
                  end
               end
            end
            STOP: begin
               if (!activate) abort <= 1'b1;
               timer <= bit_end ? '0 : timer + 1'b1;
               if (bit_end) begin
                  if (abort || !activate) begin
                     abort <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else if (hdr) begin
                     hdr      <= 1'b0;
                     addr     <= '0;
                     mem_addr <= '0;
                     mem_oe   <= 1'b1;
                     state    <= FETCH;
                  end else if (addr == A_LAST) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= FIN;
                  end else begin
                     addr     <= addr + 1'b1;
                     mem_addr <= addr + 1'b1;
                     mem_oe   <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            FIN: begin
               if (!activate) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_reader.sv
// Bench for sample_reader: frame-level timing model checked every cycle, plus a
// UART decoder and literal expectations for the directed frames.
module tb_sample_reader;

   localparam int         C      = 4;
   localparam int         AW     = 3;
   localparam int         DEPTH  = 4;
   localparam logic [7:0] HDR    = 8'hA5;
   localparam int         P      = 10*C + 2;
   localparam int         E0     = 10*C;
   localparam int         DONE_E = E0 + DEPTH*P;

   logic          clk_50mhz = 1'b0;
   logic          reset     = 1'b0;
   logic          activate  = 1'b0;
   logic          done, busy, mem_oe, txd;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data;
   logic [7:0]    mem [8];

   assign mem_data = mem[mem_addr];

   always #5 clk_50mhz = ~clk_50mhz;

   sample_reader #(.CLKS_PER_BIT(C), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .HEADER(HDR)) dut (
      .clk_50mhz(clk_50mhz), .reset(reset), .activate(activate), .done(done), .busy(busy),
      .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_data(mem_data), .txd(txd)
   );

   int vectors = 0;
   int miscompares = 0;

   // model state: 0 idle, 1 frame running, 2 done held
   int ecnt = 0, mode = 0, t0 = 0, kend = -1, addr_exp = 0, done_edge = -1, oe_count = 0;
   bit need_low = 0;
   bit e_txd, e_busy, e_oe, e_done;
   int rxq[$];
   bit ubusy = 0;
   int uc = 0;
   logic [7:0] ub;

   function automatic bit frame_bit(int slot, logic [7:0] b);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   // edge at which a frame dropped at edge k goes idle
   function automatic int abort_end(int k);
      int d;
      if (k <= E0) return E0;
      d = (k - E0) % P;
      if (d <= 2) return k;
      return k + (P - d);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int k, r, m, p;
      forever begin
         @(posedge clk_50mhz);
         ecnt++;
         if (!reset) begin
            mode = 0; need_low = 0; addr_exp = 0;
         end else begin
            case (mode)
               0: if (activate && !need_low) begin
                     mode = 1; t0 = ecnt; kend = -1; oe_count = 0; done_edge = -1;
                  end else if (!activate) need_low = 0;
               1: begin
                     k = ecnt - t0;
                     if (kend < 0 && !activate) kend = abort_end(k);
                     if (kend >= 0 && k >= kend) begin
                        mode = 0; need_low = 1;
                     end else if (k == DONE_E) begin
                        mode = 2; done_edge = k;
                     end
                  end
               default: if (!activate) mode = 0;
            endcase
         end
         #1;
         e_txd = 1; e_busy = 0; e_oe = 0; e_done = (mode == 2);
         if (mode == 1) begin
            k = ecnt - t0;
            e_busy = 1;
            if (k < E0) e_txd = frame_bit(k / C, HDR);
            else begin
               r = k - E0; m = r / P; p = r % P;
               if (p < 2) begin e_oe = 1; addr_exp = m; end
               else e_txd = frame_bit((p - 2) / C, mem[m]);
            end
         end
         if (mem_oe === 1'b1) oe_count++;
         vectors++;
         if (txd !== e_txd || busy !== e_busy || mem_oe !== e_oe || done !== e_done ||
             int'(mem_addr) !== addr_exp) begin
            miscompares++;
            $display("FAIL cycle %0d: txd/busy/oe/done/addr got %b%b%b%b/%0d expected %b%b%b%b/%0d",
                     ecnt, txd, busy, mem_oe, done, mem_addr, e_txd, e_busy, e_oe, e_done, addr_exp);
         end
         // UART decoder samples mid-bit
         if (!reset) ubusy = 0;
         else if (!ubusy) begin
            if (txd === 1'b0) begin ubusy = 1; uc = 0; end
         end else begin
            uc++;
            if (uc >= C/2 && (uc - C/2) % C == 0) begin
               k = (uc - C/2) / C;
               if (k >= 1 && k <= 8) ub[k-1] = txd;
               if (k == 9) begin
                  rxq.push_back(txd === 1'b1 ? int'(ub) : -1);
                  ubusy = 0;
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_50mhz);
   endtask

   task automatic check_bytes(input string name, input int exp_b[$]);
      chk({name, "_len"}, rxq.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < rxq.size(); i++) chk({name, "_byte"}, rxq[i], exp_b[i]);
   endtask

   initial begin
      int exp_b[$];
      int drop;
      mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF; mem[3] = 8'h00;
      for (int i = 4; i < 8; i++) mem[i] = 8'h00;
      cyc(3);
      reset = 1'b1;
      cyc(2);

      // two identical frames with handshake hold
      for (int f = 0; f < 2; f++) begin
         rxq.delete();
         activate = 1'b1;
         cyc(DONE_E + 21);
         chk("done_edge", done_edge, 208);
         chk("oe_cycles", oe_count, 8);
         exp_b = '{8'hA5, 8'h01, 8'h80, 8'hFF, 8'h00};
         check_bytes("frame", exp_b);
         activate = 1'b0;
         cyc(3);
      end

      // abort mid sample 0: sampled low at edge 60
      rxq.delete();
      activate = 1'b1;
      cyc(60);
      activate = 1'b0;
      cyc(40);
      chk("abort_done_edge", done_edge, -1);
      chk("abort_oe_cycles", oe_count, 2);
      exp_b = '{8'hA5, 8'h01};
      check_bytes("abort", exp_b);

      // reset mid header, activate stays high -> restart from header
      activate = 1'b1;
      cyc(25);
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      rxq.delete();
      cyc(DONE_E + 5);
      chk("restart_done_edge", done_edge, 208);
      exp_b = '{8'hA5, 8'h01, 8'h80, 8'hFF, 8'h00};
      check_bytes("restart", exp_b);
      activate = 1'b0;
      cyc(3);

      // randomized frames, aborts and resets
      for (int it = 0; it < 18; it++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
         activate = 1'b1;
         case ($urandom_range(0, 2))
            0: begin
               cyc(DONE_E + $urandom_range(1, 10));
               activate = 1'b0;
            end
            1: begin
               drop = $urandom_range(1, DONE_E + 3);
               cyc(drop);
               activate = 1'b0;
               cyc($urandom_range(0, 3));
               activate = 1'b1;
               cyc(P + 5);
               activate = 1'b0;
               cyc(P);
            end
            default: begin
               cyc($urandom_range(1, DONE_E));
               reset = 1'b0;
               cyc($urandom_range(1, 2));
               reset = 1'b1;
               activate = 1'b0;
            end
         endcase
         cyc($urandom_range(1, 4));
      end
      cyc(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
